// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: primary writeback always wins, deferred
// secondary writes queue in order and drain into idle write-port cycles.
module wb_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pri_valid,
    input  logic [2:0]  pri_num,
    input  logic [15:0] pri_data,
    input  logic        sec_valid,
    input  logic [2:0]  sec_num,
    input  logic [15:0] sec_data,
    input  logic        flush,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        full,
    output logic [7:0]  pending,
    output logic        overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DEPTH-1:0] live;
    logic [2:0]       num_q  [DEPTH];
    logic [15:0]      data_q [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    logic             overflow_q;

    logic empty, pop, bypass, collide, want_queue, push, drop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    // A sec request is older than a same-cycle pri write, so a matching
    // register number makes it dead on arrival.
    always_comb begin
        empty      = (count == '0);
        pop        = !pri_valid && !empty;
        bypass     = !pri_valid && empty && sec_valid && !flush;
        collide    = pri_valid && sec_valid && (sec_num == pri_num);
        want_queue = sec_valid && !flush && !collide && !bypass;
        push       = want_queue && ((count != FULL_CNT) || pop);
        drop       = want_queue && (count == FULL_CNT) && !pop;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (rst) begin
            if (pri_valid) begin
                rf_we    = 1'b1;
                rf_waddr = pri_num;
                rf_wdata = pri_data;
            end else if (!empty) begin
                // Dead head entries are popped without a write; a flush
                // discards the head write along with the rest of the queue.
                if (live[head] && !flush) begin
                    rf_we    = 1'b1;
                    rf_waddr = num_q[head];
                    rf_wdata = data_q[head];
                end
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_waddr = sec_num;
                rf_wdata = sec_data;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every bit update
    // in this block sees the pre-edge values of head, tail and live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            live       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                live  <= '0;
            end else begin
                if (pri_valid) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (live[i] && (num_q[i] == pri_num)) live[i] <= 1'b0;
                    end
                end
                if (pop) begin
                    live[head] <= 1'b0;
                    head       <= next_ptr(head);
                end
                if (push) begin
                    live[tail] <= 1'b1;
                    tail       <= next_ptr(tail);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: entry payloads carry no reset; the live bits alone decide whether
    // a slot's contents are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            num_q[tail]  <= sec_num;
            data_q[tail] <= sec_data;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) pending[num_q[i]] = 1'b1;
        end
    end

    assign full     = (count == FULL_CNT);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (DEPTH = 2).
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pri_valid = 1'b0;
    logic [2:0]  pri_num = '0;
    logic [15:0] pri_data = '0;
    logic        sec_valid = 1'b0;
    logic [2:0]  sec_num = '0;
    logic [15:0] sec_data = '0;
    logic        flush = 1'b0;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        full;
    logic [7:0]  pending;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    wb_write_arbiter #(.DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pri_valid(pri_valid),
        .pri_num  (pri_num),
        .pri_data (pri_data),
        .sec_valid(sec_valid),
        .sec_num  (sec_num),
        .sec_data (sec_data),
        .flush    (flush),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .full     (full),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs just after the falling edge.
    task automatic drive(input logic pv, input logic [2:0] pn, input logic [15:0] pd,
                         input logic sv, input logic [2:0] sn, input logic [15:0] sd,
                         input logic fl);
        @(negedge clk);
        pri_valid = pv; pri_num = pn; pri_data = pd;
        sec_valid = sv; sec_num = sn; sec_data = sd;
        flush = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
        check({tag, ".we"}, 32'(rf_we), 32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(rf_waddr), 32'(a));
            check({tag, ".data"}, 32'(rf_wdata), 32'(d));
        end
    endtask

    task automatic check_regs(input string tag, input logic f, input logic [7:0] p, input logic o);
        check({tag, ".full"}, 32'(full), 32'(f));
        check({tag, ".pending"}, 32'(pending), 32'(p));
        check({tag, ".overflow"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        // Reset state
        #2;
        check_wr("rst_hold", 1'b0, 3'd0, 16'h0);
        check_regs("rst_hold", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_regs("post_rst", 1'b0, 8'h00, 1'b0);

        // Bypass on an idle port
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h1234, 1'b0);
        check_wr("bypass", 1'b1, 3'd5, 16'h1234);
        tick();
        check_regs("bypass", 1'b0, 8'h00, 1'b0);

        // Contention: primary busy for three cycles
        drive(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'hAAAA, 1'b0);
        check_wr("cont_a", 1'b1, 3'd1, 16'h0101);
        tick();
        check_regs("cont_a", 1'b0, 8'h04, 1'b0);
        drive(1'b1, 3'd1, 16'h0102, 1'b1, 3'd3, 16'hBBBB, 1'b0);
        check_wr("cont_b", 1'b1, 3'd1, 16'h0102);
        tick();
        check_regs("cont_b", 1'b1, 8'h0C, 1'b0);
        drive(1'b1, 3'd1, 16'h0103, 1'b0, 3'd0, 16'h0, 1'b0);
        check_wr("cont_c", 1'b1, 3'd1, 16'h0103);
        tick();
        check_regs("cont_c", 1'b1, 8'h0C, 1'b0);
        idle();
        check_wr("drain_r2", 1'b1, 3'd2, 16'hAAAA);
        tick();
        check_regs("drain_r2", 1'b0, 8'h08, 1'b0);
        idle();
        check_wr("drain_r3", 1'b1, 3'd3, 16'hBBBB);
        tick();
        check_regs("drain_r3", 1'b0, 8'h00, 1'b0);
        idle();
        check_wr("drained", 1'b0, 3'd0, 16'h0);
        tick();

        // Squash of a queued entry by a newer primary write
        drive(1'b1, 3'd7, 16'h7777, 1'b1, 3'd4, 16'h1111, 1'b0);
        tick();
        check_regs("sq_queue", 1'b0, 8'h10, 1'b0);
        drive(1'b1, 3'd4, 16'h2222, 1'b0, 3'd0, 16'h0, 1'b0);
        check_wr("sq_pri", 1'b1, 3'd4, 16'h2222);
        tick();
        check_regs("sq_pri", 1'b0, 8'h00, 1'b0);
        idle();
        check_wr("sq_deadpop", 1'b0, 3'd0, 16'h0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'hCAFE, 1'b0);
        check_wr("sq_empty_bypass", 1'b1, 3'd6, 16'hCAFE);
        tick();

        // Same-cycle collision on r6
        drive(1'b1, 3'd6, 16'h0006, 1'b1, 3'd6, 16'h0600, 1'b0);
        check_wr("collide", 1'b1, 3'd6, 16'h0006);
        tick();
        check_regs("collide", 1'b0, 8'h00, 1'b0);
        idle();
        check_wr("collide_none", 1'b0, 3'd0, 16'h0);
        tick();

        // Overflow, pop-in-full-cycle acceptance, then flush
        drive(1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'hAAAA, 1'b0);
        tick();
        drive(1'b1, 3'd1, 16'h0001, 1'b1, 3'd3, 16'hBBBB, 1'b0);
        tick();
        check_regs("fill", 1'b1, 8'h0C, 1'b0);
        drive(1'b1, 3'd1, 16'h0011, 1'b1, 3'd5, 16'h5555, 1'b0);
        check_wr("ovf_pri", 1'b1, 3'd1, 16'h0011);
        tick();
        check_regs("ovf", 1'b1, 8'h0C, 1'b1);
        drive(1'b1, 3'd1, 16'h0012, 1'b0, 3'd0, 16'h0, 1'b0);
        tick();
        check_regs("ovf_sticky", 1'b1, 8'h0C, 1'b1);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h7777, 1'b0);
        check_wr("full_pop", 1'b1, 3'd2, 16'hAAAA);
        tick();
        check_regs("full_pop", 1'b1, 8'h88, 1'b1);
        drive(1'b1, 3'd0, 16'h5A5A, 1'b1, 3'd4, 16'h4444, 1'b1);
        check_wr("flush_pri", 1'b1, 3'd0, 16'h5A5A);
        tick();
        check_regs("flush", 1'b0, 8'h00, 1'b1);
        idle();
        check_wr("flush_empty", 1'b0, 3'd0, 16'h0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4444, 1'b0);
        check_wr("flush_bypass", 1'b1, 3'd4, 16'h4444);
        tick();

        // Mid-operation reset with two queued entries
        drive(1'b1, 3'd1, 16'h0001, 1'b1, 3'd2, 16'hAAAA, 1'b0);
        tick();
        drive(1'b1, 3'd1, 16'h0001, 1'b1, 3'd3, 16'hBBBB, 1'b0);
        tick();
        check_regs("pre_rst", 1'b1, 8'h0C, 1'b1);
        idle();
        check_wr("pre_rst_head", 1'b1, 3'd2, 16'hAAAA);
        #1 rst = 1'b0;
        #1;
        check_wr("in_rst", 1'b0, 3'd0, 16'h0);
        check_regs("in_rst", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_wr("rst_rel", 1'b0, 3'd0, 16'h0);
        tick();
        check_regs("rst_rel", 1'b0, 8'h00, 1'b0);
        idle();
        check_wr("no_stale", 1'b0, 3'd0, 16'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
